// File: rtl/sd_rom_sector_arbiter.sv
// rtl/sd_rom_sector_arbiter.sv - two-requester arbiter streaming 512-byte sectors from the content ROM
// Optional macro SD_ARB_FIXED_PRIO_EN: requester 0 always wins ties instead of round-robin.
module sd_rom_sector_arbiter #(
  parameter int ADDR_W = 64,
  parameter int SECT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  input  logic [1:0][SECT_W-1:0] req_sector,
  output logic [1:0]             req_ready,
  output logic [1:0]             rd_valid,
  output logic [7:0]             rd_data,
  output logic                   rd_last,
  output logic                   busy,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [7:0]             rom_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t              state;
  logic [8:0]          offset;
  logic [ADDR_W-1:0]   base;
  logic                owner;
  logic                grant;
  logic [ADDR_W-1:0]   sector_base;
  logic [8:0]          next_offset;

`ifndef SD_ARB_FIXED_PRIO_EN
  logic                rr_last;
`endif

  always_comb begin
    grant = 1'b0;
`ifdef SD_ARB_FIXED_PRIO_EN
    grant = ~req_valid[0];
`else
    if (req_valid == 2'b11)
      grant = ~rr_last;
    else
      grant = req_valid[1];
`endif
    req_ready = 2'b00;
    if (state == IDLE && rst_n)
      req_ready[grant] = req_valid[grant];
  end

  // Sector number becomes bits [SECT_W+8:9] of the byte address, zero-extended.
  assign sector_base = {{(ADDR_W-SECT_W-9){1'b0}}, req_sector[grant], 9'b0};
  assign next_offset = offset + 9'd1;
  assign rd_data     = rom_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      offset   <= 9'd0;
      base     <= '0;
      owner    <= 1'b0;
      rom_addr <= '0;
      rd_valid <= 2'b00;
      rd_last  <= 1'b0;
      busy     <= 1'b0;
`ifndef SD_ARB_FIXED_PRIO_EN
      rr_last  <= 1'b1;
`endif
    end else begin
      rd_valid <= 2'b00;
      rd_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_ready) begin
            base     <= sector_base;
            owner    <= grant;
            busy     <= 1'b1;
            rom_addr <= sector_base;
            offset   <= 9'd0;
            state    <= STREAM;
`ifndef SD_ARB_FIXED_PRIO_EN
            rr_last  <= grant;
`endif
          end
        end
        STREAM: begin
          // Data for the address issued this cycle returns next cycle, so framing lags by one.
          rd_valid <= owner ? 2'b10 : 2'b01;
          rd_last  <= (offset == 9'd511);
          if (offset == 9'd511) begin
            offset <= 9'd0;
            state  <= DRAIN;
          end else begin
            offset   <= next_offset;
            rom_addr <= base + {{(ADDR_W-9){1'b0}}, next_offset};
          end
        end
        DRAIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_rom_sector_arbiter.sv
// tb/tb_sd_rom_sector_arbiter.sv - directed bench for sd_rom_sector_arbiter
module tb_sd_rom_sector_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0][31:0] req_sector;
  logic [1:0]       req_ready;
  logic [1:0]       rd_valid;
  logic [7:0]       rd_data;
  logic             rd_last;
  logic             busy;
  logic [63:0]      rom_addr;
  logic [7:0]       rom_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sd_rom_sector_arbiter #(.ADDR_W(64), .SECT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_sector(req_sector),
    .req_ready (req_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
  );

  function automatic logic [7:0] rom_fn(input logic [63:0] a);
    return a[7:0] ^ a[15:8] ^ a[39:32] ^ 8'hA5;
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  // Called in cycle T with the request already driven; walks T+1..T+514 and returns at T+514.
  task automatic stream_check(input int own, input logic [31:0] sect, input int raise_at,
                              input logic [31:0] raise_sect, input bit drop, input string nm,
                              output logic [63:0] last_addr);
    logic [63:0] base;
    logic [1:0]  oh;
    logic [1:0]  exp_v;
    int e_addr = 0, e_valid = 0, e_data = 0, e_last = 0, e_busy = 0, e_rdy = 0;
    int k_addr = 0, k_data = 0;
    base = {23'b0, sect, 9'b0};
    oh   = (own == 1) ? 2'b10 : 2'b01;
    last_addr = '0;
    #1;
    checks++;
    if (req_ready !== oh) begin
      errors++;
      $display("FAIL %s accept: req_ready=%b expected %b", nm, req_ready, oh);
    end
    for (int k = 1; k <= 514; k++) begin
      @(negedge clk);
      if (k == 1 && drop) req_valid[own] = 1'b0;
      if (k == raise_at) begin
        req_sector[1] = raise_sect;
        req_valid[1]  = 1'b1;
      end
      if (k == 512) last_addr = rom_addr;
      if (k <= 512 && rom_addr !== base + 64'(k - 1)) begin
        if (e_addr == 0) k_addr = k;
        e_addr++;
      end
      exp_v = (k >= 2 && k <= 513) ? oh : 2'b00;
      if (rd_valid !== exp_v) e_valid++;
      if (k >= 2 && k <= 513 && rd_data !== rom_fn(base + 64'(k - 2))) begin
        if (e_data == 0) k_data = k;
        e_data++;
      end
      if (rd_last !== (k == 513)) e_last++;
      if (busy !== (k <= 513)) e_busy++;
      if (k <= 513 && req_ready !== 2'b00) e_rdy++;
    end
    checks++;
    if (e_addr != 0) begin
      errors++;
      $display("FAIL %s rom_addr: bad_beats=%0d expected 0 (first at T+%0d)", nm, e_addr, k_addr);
    end
    checks++;
    if (e_valid != 0) begin
      errors++;
      $display("FAIL %s rd_valid: bad_beats=%0d expected 0", nm, e_valid);
    end
    checks++;
    if (e_data != 0) begin
      errors++;
      $display("FAIL %s rd_data: bad_beats=%0d expected 0 (first at T+%0d)", nm, e_data, k_data);
    end
    checks++;
    if (e_last != 0) begin
      errors++;
      $display("FAIL %s rd_last: bad_beats=%0d expected 0", nm, e_last);
    end
    checks++;
    if (e_busy != 0) begin
      errors++;
      $display("FAIL %s busy: bad_beats=%0d expected 0", nm, e_busy);
    end
    checks++;
    if (e_rdy != 0) begin
      errors++;
      $display("FAIL %s ready_while_busy: bad_beats=%0d expected 0", nm, e_rdy);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    req_sector[0] = 32'd1;
    req_sector[1] = 32'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset req_ready: got %b expected 00", req_ready); end
    checks++;
    if (rd_valid !== 2'b00) begin errors++; $display("FAIL reset rd_valid: got %b expected 00", rd_valid); end
    checks++;
    if (rd_last !== 1'b0) begin errors++; $display("FAIL reset rd_last: got %b expected 0", rd_last); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++;
    if (rom_addr !== 64'd0) begin errors++; $display("FAIL reset rom_addr: got %h expected 0", rom_addr); end
    req_valid = 2'b00;
    rst_n     = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_req0();
    logic [63:0] la;
    req_sector[0] = 32'd0;
    req_valid[0]  = 1'b1;
    stream_check(0, 32'd0, 0, 32'd0, 1'b1, "req0_sector0", la);
  endtask

  task automatic test_single_req1();
    logic [63:0] la;
    req_sector[1] = 32'd3;
    req_valid[1]  = 1'b1;
    stream_check(1, 32'd3, 0, 32'd0, 1'b1, "req1_sector3", la);
    checks++;
    if (la !== 64'h7FF) begin errors++; $display("FAIL req1_sector3 last_addr: got %h expected 7ff", la); end
  endtask

  task automatic test_round_robin();
    logic [63:0] la;
    int order [4];
`ifdef SD_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0};
`else
    order = '{0, 1, 0, 1};
`endif
    rst_n = 1'b0;
    req_sector[0] = 32'd5;
    req_sector[1] = 32'd9;
    req_valid = 2'b11;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      stream_check(order[i], (order[i] == 1) ? 32'd9 : 32'd5, 0, 32'd0, 1'b0, "tie_order", la);
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_late_request();
    logic [63:0] la;
    req_sector[0] = 32'd7;
    req_valid[0]  = 1'b1;
    stream_check(0, 32'd7, 100, 32'd2, 1'b1, "late_first", la);
    stream_check(1, 32'd2, 0, 32'd0, 1'b1, "late_second", la);
  endtask

  task automatic test_reset_mid();
    logic [63:0] la;
    req_sector[0] = 32'd4;
    req_valid[0]  = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst accept: req_ready=%b expected 01", req_ready); end
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) req_valid[0] = 1'b0;
    end
    checks++;
    if (rom_addr !== 64'h800 + 64'd199) begin
      errors++;
      $display("FAIL midrst pre_addr: got %h expected %h", rom_addr, 64'h800 + 64'd199);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_valid !== 2'b00) begin errors++; $display("FAIL midrst rd_valid: got %b expected 00", rd_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst busy: got %b expected 0", busy); end
    checks++;
    if (rom_addr !== 64'd0) begin errors++; $display("FAIL midrst rom_addr: got %h expected 0", rom_addr); end
    rst_n = 1'b1;
    req_sector[0] = 32'd6;
    req_valid[0]  = 1'b1;
    stream_check(0, 32'd6, 0, 32'd0, 1'b1, "after_midrst", la);
  endtask

  task automatic test_max_sector();
    logic [63:0] la;
    req_sector[0] = 32'hFFFF_FFFF;
    req_valid[0]  = 1'b1;
    stream_check(0, 32'hFFFF_FFFF, 0, 32'd0, 1'b1, "max_sector", la);
    checks++;
    if (la !== 64'h0000_01FF_FFFF_FFFF) begin
      errors++;
      $display("FAIL max_sector last_addr: got %h expected 1ffffffffff", la);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 2'b00;
    req_sector = '0;
    test_reset();
    test_single_req0();
    test_single_req1();
    test_round_robin();
    test_late_request();
    test_reset_mid();
    test_max_sector();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
